// File: rtl/dmem_bus_pkg.sv
// ============================================================================
// Module : dmem_bus_pkg
// Brief  : Shared encodings for the data-memory bus interface.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_bus_pkg;

   typedef logic [1:0] size_t;

   localparam size_t SZ_WORD = 2'b00;
   localparam size_t SZ_HALF = 2'b01;
   localparam size_t SZ_BYTE = 2'b10;
   localparam size_t SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_RSVD     = 2'b10;
   localparam logic [1:0] FC_TIMEOUT  = 2'b11;

   localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
   localparam logic [31:0] EXIT_ADDR   = 32'hF000_0004;

   // Only word and half accesses carry an alignment constraint.
   function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
      return ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
             ((size == SZ_HALF) && addr_lo[0]);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bus_if_if.sv
// ============================================================================
// Module : dmem_bus_if_if
// Brief  : Pipeline request/response and external bus control bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_bus_if_if #(
   parameter int BIT_WIDTH = 32
);
   import dmem_bus_pkg::*;

   logic                 req_valid;
   logic                 req_write;
   size_t                req_size;
   logic                 req_signed;
   logic [BIT_WIDTH-1:0] req_addr;
   logic [BIT_WIDTH-1:0] req_wdata;
   logic                 stall;
   logic                 done;
   logic [BIT_WIDTH-1:0] rdata;
   logic                 fault;
   logic [1:0]           fault_code;

   logic [BIT_WIDTH-1:0] DAD;
   logic                 MREQ;
   logic                 WRITE;
   size_t                SIZE;
   logic                 ACKD_n;

   modport master (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
      output stall, done, rdata, fault, fault_code, DAD, MREQ, WRITE, SIZE
   );

   modport slave (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
      input  stall, done, rdata, fault, fault_code, DAD, MREQ, WRITE, SIZE
   );

endinterface

`default_nettype wire

// File: rtl/dmem_bus_if_load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Sign/zero extension of right-justified half and byte load data.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
   import dmem_bus_pkg::*;
#(
   parameter int BIT_WIDTH = 32
) (
   input  wire size_t                size,
   input  wire logic                 sign_ext,
   input  wire logic [BIT_WIDTH-1:0] raw,
   output logic      [BIT_WIDTH-1:0] ext
);

   always_comb begin
      ext = raw;
      case (size)
         SZ_HALF: ext = {{(BIT_WIDTH-16){sign_ext & raw[15]}}, raw[15:0]};
         SZ_BYTE: ext = {{(BIT_WIDTH-8){sign_ext & raw[7]}}, raw[7:0]};
         default: ext = raw;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_bus_if.sv
// ============================================================================
// Module : dmem_bus_if
// Brief  : MEM-stage load/store to external data-bus transaction engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bus_if
   import dmem_bus_pkg::*;
#(
   parameter int BIT_WIDTH   = 32,
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   dmem_bus_if_if.master             bus,
   inout  wire       [BIT_WIDTH-1:0] DDT
);

   localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(ACK_TIMEOUT);
   localparam bit               c_timeout_en = (ACK_TIMEOUT != 0);

   state_t               r_state;
   logic                 r_mreq;
   logic                 r_write;
   size_t                r_size;
   logic [BIT_WIDTH-1:0] r_dad;
   logic                 r_done;
   logic                 r_fault;
   logic [1:0]           r_fault_code;
   logic [BIT_WIDTH-1:0] r_rdata;
   logic [CNT_W-1:0]     r_cnt;

   logic [CNT_W-1:0]     w_cnt_next;
   logic [BIT_WIDTH-1:0] w_ext;

   assign w_cnt_next = r_cnt + CNT_W'(1);

   load_extend #(
      .BIT_WIDTH (BIT_WIDTH)
   ) u_load_extend (
      .size     (r_size),
      .sign_ext (bus.req_signed),
      .raw      (DDT),
      .ext      (w_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_mreq       <= 1'b0;
         r_write      <= 1'b0;
         r_size       <= SZ_WORD;
         r_dad        <= '0;
         r_done       <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_code <= FC_NONE;
         r_rdata      <= '0;
         r_cnt        <= '0;
      end else begin
         r_done       <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_code <= FC_NONE;
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  if (bus.req_size == SZ_RSVD) begin
                     r_state      <= ST_RESP;
                     r_done       <= 1'b1;
                     r_fault      <= 1'b1;
                     r_fault_code <= FC_RSVD;
                  end else if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                     r_state      <= ST_RESP;
                     r_done       <= 1'b1;
                     r_fault      <= 1'b1;
                     r_fault_code <= FC_MISALIGN;
                  end else begin
                     r_state <= ST_ACCESS;
                     r_dad   <= bus.req_addr;
                     r_write <= bus.req_write;
                     r_size  <= bus.req_size;
                     r_mreq  <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
            end
            ST_ACCESS: begin
               // The acknowledge is tested first so it wins over a coincident timeout.
               if (!bus.ACKD_n) begin
                  r_state <= ST_RESP;
                  r_mreq  <= 1'b0;
                  r_write <= 1'b0;
                  r_size  <= SZ_WORD;
                  r_done  <= 1'b1;
                  if (!r_write) begin
                     r_rdata <= w_ext;
                  end
               end else begin
                  r_cnt <= w_cnt_next;
                  if (c_timeout_en && (w_cnt_next == c_timeout)) begin
                     r_state      <= ST_RESP;
                     r_mreq       <= 1'b0;
                     r_write      <= 1'b0;
                     r_size       <= SZ_WORD;
                     r_done       <= 1'b1;
                     r_fault      <= 1'b1;
                     r_fault_code <= FC_TIMEOUT;
                  end
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Store data comes straight from the held request; the bus only sees it while a write is active.
   assign DDT = (r_mreq && r_write) ? bus.req_wdata : {BIT_WIDTH{1'bz}};

   assign bus.stall      = bus.req_valid & ~r_done;
   assign bus.done       = r_done;
   assign bus.fault      = r_fault;
   assign bus.fault_code = r_fault_code;
   assign bus.rdata      = r_rdata;
   assign bus.DAD        = r_dad;
   assign bus.MREQ       = r_mreq;
   assign bus.WRITE      = r_write;
   assign bus.SIZE       = r_size;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_if.sv
// ============================================================================
// Module : tb_dmem_bus_if
// Brief  : Randomized self-checking bench for dmem_bus_if with a cycle-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_bus_if;
   import dmem_bus_pkg::*;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        tb_en;
   logic [31:0] tb_ddt;
   wire  [31:0] DDT;

   always #5 clk = ~clk;

   assign DDT = tb_en ? tb_ddt : 32'bz;

   dmem_bus_if_if #(.BIT_WIDTH(32)) bus ();

   dmem_bus_if #(
      .BIT_WIDTH   (32),
      .ACK_TIMEOUT (TMO),
      .CNT_W       (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .DDT (DDT)
   );

   typedef struct {
      logic        stall, done, fault, mreq, write;
      logic [1:0]  code, size;
      logic [31:0] dad, rdata, ddt;
      bit          chk_dad;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act, expv;
   } lit_t;

   exp_t        exp_q[$];
   lit_t        lit_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          mreq_cnt = 0;
   int          stall_cnt = 0;
   int          done_cnt = 0;
   logic        last_fault = 1'b0;
   logic [1:0]  last_code = 2'b00;
   logic [31:0] m_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: actual=%h expected=%h at %0t", name, act, expv, $time);
      end
   endtask

   initial begin : compare
      exp_t e;
      lit_t l;
      forever begin
         @(negedge clk);
         while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            chk(l.name, l.act, l.expv);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",      32'(bus.stall),      32'(e.stall));
            chk("done",       32'(bus.done),       32'(e.done));
            chk("fault",      32'(bus.fault),      32'(e.fault));
            chk("fault_code", 32'(bus.fault_code), 32'(e.code));
            chk("MREQ",       32'(bus.MREQ),       32'(e.mreq));
            chk("WRITE",      32'(bus.WRITE),      32'(e.write));
            chk("SIZE",       32'(bus.SIZE),       32'(e.size));
            chk("rdata",      bus.rdata,           e.rdata);
            chk("DDT",        DDT,                 e.ddt);
            if (e.chk_dad) chk("DAD", bus.DAD, e.dad);
         end
      end
   end

   always @(negedge clk) begin
      if (bus.MREQ === 1'b1)  mreq_cnt++;
      if (bus.stall === 1'b1) stall_cnt++;
      if (bus.done === 1'b1) begin
         done_cnt++;
         last_fault = bus.fault;
         last_code  = bus.fault_code;
      end
   end

   // Expected load result by plain arithmetic: negative halves/bytes subtract the field's range.
   function automatic logic [31:0] extend(input logic [1:0] sz, input bit sg, input logic [31:0] raw);
      case (sz)
         2'b01:   return {16'h0, raw[15:0]} - ((sg && raw[15]) ? 32'h0001_0000 : 32'h0);
         2'b10:   return {24'h0, raw[7:0]} - ((sg && raw[7]) ? 32'h0000_0100 : 32'h0);
         default: return raw;
      endcase
   endfunction

   function automatic exp_t base();
      exp_t e;
      e.stall = bus.req_valid; e.done = 1'b0; e.fault = 1'b0; e.mreq = 1'b0; e.write = 1'b0;
      e.code = 2'b00; e.size = 2'b00; e.dad = 32'h0; e.rdata = m_rdata; e.ddt = tb_ddt;
      e.chk_dad = 1'b0;
      return e;
   endfunction

   task automatic cyc(input exp_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string n, input logic [31:0] a, input logic [31:0] x);
      lit_t l;
      l.name = n; l.act = a; l.expv = x;
      lit_q.push_back(l);
   endtask

   task automatic noise();
      bus.ACKD_n = 1'($urandom_range(0, 1));
      tb_en      = 1'b1;
      tb_ddt     = $urandom;
   endtask

   task automatic set_req(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
      bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wdata;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.req_valid = 1'b0; bus.req_write = 1'($urandom_range(0, 1));
         bus.req_size = 2'($urandom_range(0, 3)); bus.req_addr = $urandom;
         bus.req_wdata = $urandom; bus.req_signed = 1'($urandom_range(0, 1));
         noise();
         cyc(base());
      end
   endtask

   // ack_wait = ACCESS cycles with ACKD_n high before the acknowledging cycle.
   task automatic run_txn(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd_raw, input int ack_wait);
      exp_t e;
      bit   pre_fault, tmo;
      int   k, n;
      pre_fault = (sz == 2'b11) || (sz == 2'b00 && addr[1:0] != 2'b00) || (sz == 2'b01 && addr[0]);
      set_req(wr, sz, sg, addr, wdata);
      noise();
      e = base(); e.stall = 1'b1;
      cyc(e);
      if (pre_fault) begin
         noise();
         e = base(); e.stall = 1'b0; e.done = 1'b1; e.fault = 1'b1;
         e.code = (sz == 2'b11) ? 2'b10 : 2'b01;
         cyc(e);
         return;
      end
      k   = ack_wait + 1;
      tmo = (k > TMO);
      n   = tmo ? TMO : k;
      for (int i = 1; i <= n; i++) begin
         bus.ACKD_n = (i == k) ? 1'b0 : 1'b1;
         tb_en  = !wr;
         tb_ddt = wr ? $urandom : rd_raw;
         e = base(); e.stall = 1'b1; e.mreq = 1'b1; e.write = wr; e.size = sz;
         e.dad = addr; e.chk_dad = 1'b1; e.ddt = wr ? wdata : rd_raw;
         cyc(e);
      end
      if (!tmo && !wr) m_rdata = extend(sz, sg, rd_raw);
      noise();
      e = base(); e.stall = 1'b0; e.done = 1'b1; e.fault = tmo;
      e.code = tmo ? 2'b11 : 2'b00;
      cyc(e);
   endtask

   // Reset lands at the end of ACCESS cycle rst_at; no acknowledge is ever given.
   task automatic run_rst(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rst_at);
      exp_t e;
      set_req(wr, sz, 1'b0, addr, wdata);
      noise();
      e = base(); e.stall = 1'b1;
      cyc(e);
      for (int i = 1; i <= rst_at; i++) begin
         bus.ACKD_n = 1'b1;
         rst    = (i == rst_at);
         tb_en  = !wr;
         tb_ddt = $urandom;
         e = base(); e.stall = 1'b1; e.mreq = 1'b1; e.write = wr; e.size = sz;
         e.dad = addr; e.chk_dad = 1'b1; e.ddt = wr ? wdata : tb_ddt;
         cyc(e);
      end
      rst = 1'b0;
      bus.req_valid = 1'b0;
      m_rdata = 32'h0;
      noise();
      e = base(); e.chk_dad = 1'b1;
      cyc(e);
   endtask

   task automatic random_phase(input int count);
      bit          wr, sg;
      logic [1:0]  sz;
      logic [31:0] addr;
      int          r;
      for (int t = 0; t < count; t++) begin
         wr   = 1'($urandom_range(0, 1));
         sg   = 1'($urandom_range(0, 1));
         r    = $urandom_range(0, 15);
         sz   = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 14) ? 2'b10 : 2'b11;
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b00) addr[1:0] = 2'b00;
            if (sz == 2'b01) addr[0]   = 1'b0;
         end
         if ($urandom_range(0, 15) == 0) begin
            addr[1:0] = 2'b00;
            run_rst(wr, 2'b00, addr, $urandom, $urandom_range(1, 3));
         end else begin
            run_txn(wr, sz, sg, addr, $urandom, $urandom, $urandom_range(0, 5));
         end
         if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 2));
      end
   endtask

   initial begin : driver
      exp_t e;
      int   m0, s0, d0;
      rst = 1'b1; tb_en = 1'b1; tb_ddt = 32'h0; m_rdata = 32'h0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
      bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.ACKD_n = 1'b1;
      @(posedge clk);
      #1;
      e = base(); e.chk_dad = 1'b1;
      cyc(e);
      rst = 1'b0;
      idle(2);

      m0 = mreq_cnt; s0 = stall_cnt;
      run_txn(1'b0, SZ_WORD, 1'b0, 32'h0800_0010, $urandom, 32'hDEADBEEF, 0);
      lit("t1_rdata", bus.rdata, 32'hDEADBEEF);
      lit("t1_mreq_cycles", 32'(mreq_cnt - m0), 32'd1);
      lit("t1_stall_cycles", 32'(stall_cnt - s0), 32'd2);
      idle(1);

      run_txn(1'b0, SZ_BYTE, 1'b1, 32'h0800_0003, $urandom, 32'h0000_00F0, 1);
      lit("t2_byte_signed", bus.rdata, 32'hFFFF_FFF0);
      run_txn(1'b0, SZ_BYTE, 1'b0, 32'h0800_0003, $urandom, 32'h0000_00F0, 0);
      lit("t2_byte_unsigned", bus.rdata, 32'h0000_00F0);
      run_txn(1'b0, SZ_HALF, 1'b1, 32'h0800_0002, $urandom, 32'h0000_8001, 2);
      lit("t2_half_signed", bus.rdata, 32'hFFFF_8001);

      run_txn(1'b1, SZ_BYTE, 1'b0, STDOUT_ADDR, 32'h0000_0041, $urandom, 1);
      lit("t3_store_rdata_kept", bus.rdata, 32'hFFFF_8001);

      m0 = mreq_cnt;
      run_txn(1'b0, SZ_WORD, 1'b0, 32'h0800_0002, $urandom, $urandom, 0);
      lit("t4_misalign_code", 32'(last_code), 32'd1);
      lit("t4_misalign_no_mreq", 32'(mreq_cnt - m0), 32'd0);
      run_txn(1'b0, 2'b11, 1'b0, 32'h0800_0000, $urandom, $urandom, 0);
      lit("t4_rsvd_code", 32'(last_code), 32'd2);

      m0 = mreq_cnt;
      run_txn(1'b0, SZ_WORD, 1'b0, 32'h0800_0020, $urandom, $urandom, TMO);
      lit("t5_timeout_code", 32'(last_code), 32'd3);
      lit("t5_timeout_mreq_cycles", 32'(mreq_cnt - m0), 32'd4);
      lit("t5_timeout_rdata_kept", bus.rdata, 32'hFFFF_8001);
      m0 = mreq_cnt;
      run_txn(1'b0, SZ_WORD, 1'b0, 32'h0800_0024, $urandom, 32'h1234_5678, TMO - 1);
      lit("t5_late_ack_fault", 32'(last_fault), 32'd0);
      lit("t5_late_ack_mreq_cycles", 32'(mreq_cnt - m0), 32'd4);
      lit("t5_late_ack_rdata", bus.rdata, 32'h1234_5678);

      d0 = done_cnt;
      run_rst(1'b0, SZ_WORD, 32'h0800_0030, $urandom, 2);
      lit("t6_no_done", 32'(done_cnt - d0), 32'd0);
      lit("t6_rdata_reset", bus.rdata, 32'h0);
      run_txn(1'b0, SZ_WORD, 1'b0, 32'h0800_0030, $urandom, 32'hCAFE_F00D, 2);
      lit("t6_fresh_rdata", bus.rdata, 32'hCAFE_F00D);
      idle(1);

      random_phase(250);
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
- Load/store bus interface between the core's MEM stage and the external data-memory bus (DAD, DDT, MREQ, WRITE, SIZE, ACKD_n).
- Turns one pipeline memory request into one bus transaction.
- Stalls the pipeline until ACKD_n is asserted.
- Sign- or zero-extends load data, and detects misaligned, reserved-size and timeout faults.
- Instantiated inside top, directly downstream of the MEM stage and upstream of the external bus/memory model.

Parameters:
- BIT_WIDTH, 32, data/address width
- ACK_TIMEOUT, 255, max cycles waiting for ACKD_n before bus error; 0 disables timeout
- CNT_W, 8, timeout counter width (must hold ACK_TIMEOUT)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  MEM stage has a memory op; held stable until done
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 word, 01 half, 10 byte, 11 reserved
- req_signed  in  1  load sign-extend enable
- req_addr  in  BIT_WIDTH  byte address
- req_wdata  in  BIT_WIDTH  store data, right-justified
- stall  out  1  freeze pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  BIT_WIDTH  extended load data, valid with done
- fault  out  1  one-cycle pulse, coincident with done, on any error
- fault_code  out  2  01 misaligned, 10 reserved size, 11 timeout
- DAD  out  BIT_WIDTH  bus address
- MREQ  out  1  bus request
- WRITE  out  1  bus direction
- SIZE  out  2  bus size, same encoding as req_size
- ACKD_n  in  1  bus acknowledge, active-low
- DDT  inout  BIT_WIDTH  bus data

Behaviour:
- Reset values (synchronous, rst high at rising edge):
  - State IDLE; MREQ=0, WRITE=0, SIZE=00, DAD=0.
  - done=0, fault=0, fault_code=00, rdata=0, timeout counter=0.
  - DDT released (high-Z).
- States: IDLE, ACCESS, RESP.
- IDLE, req_valid=1:
  - Misaligned (word with addr[1:0]!=0, or half with addr[0]!=0) or size=11: go to RESP with done=1, fault=1 and the matching fault_code. No bus cycle is issued.
  - Otherwise: register DAD=req_addr, WRITE=req_write, SIZE=req_size, MREQ=1; go to ACCESS.
- ACCESS:
  - DDT is driven with req_wdata while MREQ&WRITE; high-Z otherwise.
  - Store data is right-justified: half on [15:0], byte on [7:0]; upper bits are driven as given.
  - Counter increments each cycle ACKD_n=1.
  - ACKD_n sampled 0 at rising edge:
    - MREQ, WRITE, SIZE return to 0 and DDT is released at that edge.
    - done=1; go to RESP.
    - For a load, rdata is captured at the same edge:
      - word: DDT as-is.
      - half: DDT[15:0], sign-extended if req_signed, else zero-extended.
      - byte: DDT[7:0], extended the same way.
      - Upper DDT bits are ignored for half/byte.
  - Counter reaches ACK_TIMEOUT (ACK_TIMEOUT!=0):
    - Drop MREQ; go to RESP with done=1, fault=1, fault_code=11, rdata unchanged.
- RESP:
  - done/fault high for exactly this cycle; go to IDLE.
  - req_valid is ignored here, because the pipeline advances at the end of RESP.
- stall = req_valid & ~done (combinational).
- Minimum cost: 3 cycles per access (IDLE accept, ≥1 ACCESS, RESP). Back-to-back accesses leave ≥1 cycle of MREQ=0 between them.
- Latency from accept to done: acknowledge cycles + 1.
- Stores: rdata keeps its previous value.
- Loads: on fault, rdata is unchanged.
- rst in any state: all outputs return to their reset values at that edge, the transaction is abandoned, and there is no done pulse.
- ACKD_n=0 while in IDLE or RESP: ignored.
- ACKD_n and timeout at the same edge: the acknowledge wins.

Decomposition:
- Shared package, dmem_bus_pkg:
  - SIZE encodings (SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10).
  - State encoding.
  - fault_code constants.
  - STDOUT/EXIT address constants, for the benches.
- Sub-module load_extend:
  - Combinational; inputs size, signed, raw data; output extended word.
  - Reused by the writeback path.

Test Plan:
1. Load word: addr 0x08000010, bus returns 0xDEADBEEF after 1 cycle → MREQ high 1 cycle, SIZE=00, done after 3 cycles, rdata=0xDEADBEEF, stall high for 2 cycles.
2. Signed byte/half loads:
   - byte at 0x08000003, DDT=0x000000F0, signed → rdata=0xFFFFFFF0; unsigned → 0x000000F0.
   - half at 0x08000002, DDT=0x00008001, signed → rdata=0xFFFF8001.
3. Store byte to 0xF0000000 with wdata 0x00000041 → WRITE=1, SIZE=10, DDT=0x00000041 while MREQ; DDT high-Z after the acknowledge; rdata unchanged.
4. Misaligned/reserved:
   - word load at 0x08000002 → fault=1, fault_code=01, MREQ never asserted.
   - size=11 → fault_code=10.
5. Timeout with ACK_TIMEOUT=4 and ACKD_n held 1 → MREQ high 4 cycles, then done=fault=1, fault_code=11.
   - Same run with ACKD_n pulled low on cycle 4 → normal done, no fault.
6. rst asserted on the 2nd cycle of a 3-cycle-latency load → MREQ=0 and DDT high-Z at that edge, no done.
   - A fresh request after rst deassertion completes normally.
